// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - PC sequencer and registered fetch stage for the MIPS instruction ROM
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter logic [31:0] IMEM_BYTES = 32'd80,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_instr,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_instr_q, out_instr_d;
    logic [31:0]      out_pc_q, out_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        stage_free;
    logic        handshake;
    logic        redir_bad;
    logic        redir_ok;
    logic        range_fault;
    logic        self_jump;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;

    assign pc_plus4    = pc_q + 32'd4;
    assign jump_target = {pc_plus4[31:28], imem_instr[25:0], 2'b00};
    assign handshake   = out_valid_q && out_ready;
    assign stage_free  = !out_valid_q || out_ready;
    assign redir_bad   = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redir_ok    = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign range_fault = stage_free && (pc_q >= IMEM_BYTES);
    // A `j` whose target is its own address is the program's terminating idle loop.
    assign self_jump   = (imem_instr[31:26] == 6'b000010) && (jump_target == pc_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'd0;
            out_pc_q    <= 32'd0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN: begin
                if (redir_bad)                      state_d = S_FAULT;
                else if (redir_ok)                  state_d = S_RUN;
                else if (range_fault)               state_d = S_FAULT;
                else if (stage_free && self_jump)   state_d = S_HALT;
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        cnt_d       = cnt_q;
        if (handshake && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        case (state_q)
            S_RUN: begin
                if (redir_bad || range_fault) begin
                    out_valid_d = 1'b0;
                end else if (redir_ok) begin
                    pc_d        = redirect_pc;
                    out_valid_d = 1'b0;
                end else if (stage_free) begin
                    out_instr_d = imem_instr;
                    out_pc_d    = pc_q;
                    out_valid_d = 1'b1;
                    if (!self_jump) pc_d = pc_plus4;
                end
            end
            S_HALT:  if (handshake) out_valid_d = 1'b0;
            S_FAULT: out_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        imem_addr   = pc_q;
        out_valid   = out_valid_q;
        out_instr   = out_instr_q;
        out_pc      = out_pc_q;
        halted      = (state_q == S_HALT);
        fault       = (state_q == S_FAULT);
        fetch_count = cnt_q;
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - directed bench for imem_fetch_ctrl with a behavioural ROM
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic        fault;
    logic [15:0] fetch_count;

    logic [31:0] rom [0:31];
    logic        force0;
    int          total;
    int          bad;

    imem_fetch_ctrl #(
        .RESET_PC   (32'd0),
        .IMEM_BYTES (32'd80),
        .CNT_W      (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        imem_instr = 32'hFFFF_FFFF;
        if (imem_addr < 32'd80) imem_instr = rom[imem_addr[6:2]];
        if (force0 && imem_addr == 32'd76) imem_instr = 32'd0;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        force0 = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 32'h2000_0000 | i;
        rom[0]  = 32'h2108_00D5;
        rom[1]  = 32'h2129_003C;
        rom[2]  = 32'h214A_0009;
        rom[3]  = 32'h010A_8018;
        rom[13] = 32'h2252_0001;
        rom[18] = 32'h0800_0013;
        rom[19] = 32'h0800_0013;

        start = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_cnt", 32'(fetch_count), 32'd0);
        chk("rst_halt", 32'(halted), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);

        // Idle without start: nothing happens even with ready/redirect.
        rst_n = 1'b1;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'd40;
        tick();
        tick();
        redirect_valid = 1'b0;
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_addr", imem_addr, 32'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("lat_bubble", 32'(out_valid), 32'd0);
        tick();
        chk("w0_valid", 32'(out_valid), 32'd1);
        chk("w0_pc", out_pc, 32'd0);
        chk("w0_instr", out_instr, 32'h2108_00D5);
        chk("w0_cnt", 32'(fetch_count), 32'd0);
        tick();
        chk("w1_pc", out_pc, 32'd4);
        chk("w1_instr", out_instr, 32'h2129_003C);
        chk("w1_cnt", 32'(fetch_count), 32'd1);
        tick();
        chk("w2_pc", out_pc, 32'd8);
        chk("w2_instr", out_instr, 32'h214A_0009);
        chk("w2_cnt", 32'(fetch_count), 32'd2);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", out_pc, 32'd8);
            chk("stall_instr", out_instr, 32'h214A_0009);
            chk("stall_addr", imem_addr, 32'd12);
            chk("stall_cnt", 32'(fetch_count), 32'd2);
        end
        out_ready = 1'b1;
        tick();
        chk("w3_pc", out_pc, 32'd12);
        chk("w3_instr", out_instr, 32'h010A_8018);
        chk("w3_cnt", 32'(fetch_count), 32'd3);
        tick();
        tick();
        tick();
        chk("w6_pc", out_pc, 32'd24);
        chk("w6_cnt", 32'(fetch_count), 32'd6);

        redirect_valid = 1'b1;
        redirect_pc = 32'd52;
        tick();
        redirect_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_cnt", 32'(fetch_count), 32'd7);
        chk("flush_addr", imem_addr, 32'd52);
        tick();
        chk("tgt_valid", 32'(out_valid), 32'd1);
        chk("tgt_pc", out_pc, 32'd52);
        chk("tgt_instr", out_instr, 32'h2252_0001);
        tick();
        chk("tgt1_pc", out_pc, 32'd56);
        chk("tgt1_cnt", 32'(fetch_count), 32'd8);

        redirect_valid = 1'b1;
        redirect_pc = 32'd72;
        tick();
        redirect_valid = 1'b0;
        chk("r72_bubble", 32'(out_valid), 32'd0);
        tick();
        chk("j72_pc", out_pc, 32'd72);
        chk("j72_instr", out_instr, 32'h0800_0013);
        chk("j72_halt", 32'(halted), 32'd0);
        tick();
        chk("j76_pc", out_pc, 32'd76);
        chk("j76_halt", 32'(halted), 32'd1);
        chk("j76_cnt", 32'(fetch_count), 32'd10);
        out_ready = 1'b0;
        tick();
        chk("halt_hold_valid", 32'(out_valid), 32'd1);
        chk("halt_hold_pc", out_pc, 32'd76);
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'd0;
        tick();
        chk("halt_drain_valid", 32'(out_valid), 32'd0);
        chk("halt_drain_cnt", 32'(fetch_count), 32'd11);
        chk("halt_addr", imem_addr, 32'd76);
        tick();
        redirect_valid = 1'b0;
        chk("halt_stay", 32'(halted), 32'd1);
        chk("halt_noredir", imem_addr, 32'd76);
        chk("halt_empty", 32'(out_valid), 32'd0);

        // Misaligned redirect.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("f1_pre_valid", 32'(out_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h3E;
        tick();
        redirect_valid = 1'b0;
        chk("f1_fault", 32'(fault), 32'd1);
        chk("f1_valid", 32'(out_valid), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("f1_sticky", 32'(fault), 32'd1);
        chk("f1_still_empty", 32'(out_valid), 32'd0);

        // Range fault: fetch runs past the populated ROM.
        force0 = 1'b1;
        do_reset();
        chk("f2_rst_fault", 32'(fault), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'd76;
        tick();
        redirect_valid = 1'b0;
        chk("f2_bubble", 32'(out_valid), 32'd0);
        tick();
        chk("f2_w76_pc", out_pc, 32'd76);
        chk("f2_w76_instr", out_instr, 32'd0);
        chk("f2_nohalt", 32'(halted), 32'd0);
        tick();
        chk("f2_fault", 32'(fault), 32'd1);
        chk("f2_valid", 32'(out_valid), 32'd0);
        chk("f2_addr", imem_addr, 32'd80);
        chk("f2_cnt", 32'(fetch_count), 32'd1);
        tick();
        chk("f2_hold_pc", out_pc, 32'd76);
        force0 = 1'b0;

        // Asynchronous reset between edges.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("ar_pre_valid", 32'(out_valid), 32'd1);
        chk("ar_pre_cnt", 32'(fetch_count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_cnt", 32'(fetch_count), 32'd0);
        chk("ar_halt", 32'(halted), 32'd0);
        chk("ar_fault", 32'(fault), 32'd0);
        chk("ar_addr", imem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("ar_idle_valid", 32'(out_valid), 32'd0);
        chk("ar_idle_addr", imem_addr, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("ar_restart_pc", out_pc, 32'd0);
        chk("ar_restart_valid", 32'(out_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
